// File: rtl/vissplit.sv
// Receive end of the visibility daisy-chain: deserialises one real/imag beat per
// valid cycle into a LENGTH-lane frame, handed off through a single holding register.

module vissplit_lane #(
    parameter int WIDTH = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic             load,
    input  logic [WIDTH-1:0] din_r,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] hold_r,
    output logic [WIDTH-1:0] hold_i
);
    logic [WIDTH-1:0] fb_r, fb_i;
    logic [WIDTH-1:0] mrg_r, mrg_i;

    // completing beat bypasses the fill buffer straight into the holding register
    assign mrg_r = wr ? din_r : fb_r;
    assign mrg_i = wr ? din_i : fb_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fb_r   <= '0;
            fb_i   <= '0;
            hold_r <= '0;
            hold_i <= '0;
        end else begin
            if (wr) begin
                fb_r <= din_r;
                fb_i <= din_i;
            end
            if (load) begin
                hold_r <= mrg_r;
                hold_i <= mrg_i;
            end
        end
    end
endmodule

module vissplit #(
    parameter int LENGTH  = 3,
    parameter int WIDTH   = 7,
    parameter bit REVERSE = 1'b0,
    parameter int CBITS   = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    seq_valid_i,
    input  logic [WIDTH-1:0]        seq_rdata_i,
    input  logic [WIDTH-1:0]        seq_idata_i,
    input  logic                    flush_i,
    input  logic                    clear_i,
    output logic                    par_valid_o,
    input  logic                    par_ready_i,
    output logic [LENGTH*WIDTH-1:0] par_rdata_o,
    output logic [LENGTH*WIDTH-1:0] par_idata_o,
    output logic [CBITS-1:0]        fill_o,
    output logic                    overflow_o
);
    logic [CBITS-1:0] fill;
    logic             beat, last, complete, load, drop;
    logic [LENGTH-1:0][WIDTH-1:0] hold_r, hold_i;

    assign beat     = seq_valid_i & ~flush_i;
    assign last     = (fill == CBITS'(LENGTH - 1));
    assign complete = beat & last;
    assign load     = complete & (~par_valid_o | par_ready_i);
    assign drop     = complete & par_valid_o & ~par_ready_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill        <= '0;
            par_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            if (flush_i)
                fill <= '0;
            else if (seq_valid_i)
                fill <= last ? '0 : fill + 1'b1;

            if (load)
                par_valid_o <= 1'b1;
            else if (par_ready_i)
                par_valid_o <= 1'b0;

            // a drop in the same cycle as clear_i keeps the flag set
            if (drop)
                overflow_o <= 1'b1;
            else if (clear_i)
                overflow_o <= 1'b0;
        end
    end

    for (genvar j = 0; j < LENGTH; j++) begin : g_lane
        localparam int SLOT = REVERSE ? j : LENGTH - 1 - j;
        logic wr;
        assign wr = beat & (fill == CBITS'(SLOT));

        vissplit_lane #(.WIDTH(WIDTH)) u_lane (
            .clock  (clock),
            .reset  (reset),
            .wr     (wr),
            .load   (load),
            .din_r  (seq_rdata_i),
            .din_i  (seq_idata_i),
            .hold_r (hold_r[j]),
            .hold_i (hold_i[j])
        );
    end

    assign par_rdata_o = hold_r;
    assign par_idata_o = hold_i;
    assign fill_o      = fill;
endmodule

// File: tb/tb_vissplit.sv
// Directed bench for vissplit: LENGTH=3, WIDTH=7, both lane orderings side by side.

module tb_vissplit;
    logic        clock, reset;
    logic        seq_valid, flush, clr, rdy;
    logic [6:0]  seq_r, seq_i;
    logic        v0, v1, o0, o1;
    logic [20:0] r0, i0, r1, i1;
    logic [1:0]  f0, f1;
    int          n_chk, n_err;

    vissplit #(.LENGTH(3), .WIDTH(7), .REVERSE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .seq_valid_i(seq_valid), .seq_rdata_i(seq_r),
        .seq_idata_i(seq_i), .flush_i(flush), .clear_i(clr), .par_valid_o(v0),
        .par_ready_i(rdy), .par_rdata_o(r0), .par_idata_o(i0), .fill_o(f0), .overflow_o(o0));

    vissplit #(.LENGTH(3), .WIDTH(7), .REVERSE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .seq_valid_i(seq_valid), .seq_rdata_i(seq_r),
        .seq_idata_i(seq_i), .flush_i(flush), .clear_i(clr), .par_valid_o(v1),
        .par_ready_i(rdy), .par_rdata_o(r1), .par_idata_o(i1), .fill_o(f1), .overflow_o(o1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {lane2, lane1, lane0}
    function automatic logic [20:0] pack(input int a, input int b, input int c);
        logic [6:0] x, y, z;
        x = a[6:0]; y = b[6:0]; z = c[6:0];
        return {x, y, z};
    endfunction

    // apply inputs at a falling edge, return at the next falling edge
    task automatic cyc(input bit v, input int r, input int i, input bit fl, input bit cl, input bit rd);
        seq_valid = v; seq_r = r[6:0]; seq_i = i[6:0]; flush = fl; clr = cl; rdy = rd;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0; seq_valid = 0; seq_r = 0; seq_i = 0; flush = 0; clr = 0; rdy = 0;
        #1;
        n_chk++; if (v0 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", v0); end
        n_chk++; if (r0 !== 21'd0 || i0 !== 21'd0) begin n_err++; $display("FAIL reset_data got %h/%h exp 0", r0, i0); end
        n_chk++; if (f0 !== 2'd0 || o0 !== 1'b0) begin n_err++; $display("FAIL reset_fill_ovf got %0d/%b exp 0/0", f0, o0); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_inorder;
        n_chk++; if (f0 !== 2'd0) begin n_err++; $display("FAIL inorder_fill0 got %0d exp 0", f0); end
        cyc(1, 1, 'h11, 0, 0, 1);
        n_chk++; if (f0 !== 2'd1) begin n_err++; $display("FAIL inorder_fill1 got %0d exp 1", f0); end
        cyc(1, 2, 'h12, 0, 0, 1);
        n_chk++; if (f0 !== 2'd2 || v0 !== 1'b0) begin n_err++; $display("FAIL inorder_fill2 got %0d/%b exp 2/0", f0, v0); end
        cyc(1, 3, 'h13, 0, 0, 1);
        n_chk++; if (v0 !== 1'b1 || f0 !== 2'd0) begin n_err++; $display("FAIL inorder_valid got %b/%0d exp 1/0", v0, f0); end
        n_chk++; if (r0 !== pack(1, 2, 3)) begin n_err++; $display("FAIL inorder_r got %h exp %h", r0, pack(1, 2, 3)); end
        n_chk++; if (i0 !== pack('h11, 'h12, 'h13)) begin n_err++; $display("FAIL inorder_i got %h exp %h", i0, pack('h11, 'h12, 'h13)); end
        n_chk++; if (r1 !== pack(3, 2, 1)) begin n_err++; $display("FAIL reverse_r got %h exp %h", r1, pack(3, 2, 1)); end
        n_chk++; if (i1 !== pack('h13, 'h12, 'h11)) begin n_err++; $display("FAIL reverse_i got %h exp %h", i1, pack('h13, 'h12, 'h11)); end
        cyc(0, 0, 0, 0, 0, 1);
        n_chk++; if (v0 !== 1'b0 || r0 !== pack(1, 2, 3)) begin n_err++; $display("FAIL inorder_consume got %b/%h exp 0/%h", v0, r0, pack(1, 2, 3)); end
    endtask

    task automatic test_overflow;
        for (int k = 1; k <= 6; k++) begin
            cyc(1, k, 'h20 + k, 0, 0, 0);
            if (k == 3) begin
                n_chk++; if (v0 !== 1'b1 || r0 !== pack(1, 2, 3)) begin n_err++; $display("FAIL ovf_held got %b/%h exp 1/%h", v0, r0, pack(1, 2, 3)); end
            end
            if (k == 5) begin
                n_chk++; if (o0 !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b exp 0", o0); end
            end
        end
        n_chk++; if (o0 !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", o0); end
        n_chk++; if (r0 !== pack(1, 2, 3) || i0 !== pack('h21, 'h22, 'h23) || v0 !== 1'b1)
            begin n_err++; $display("FAIL ovf_keep got %b/%h/%h exp 1/%h/%h", v0, r0, i0, pack(1, 2, 3), pack('h21, 'h22, 'h23)); end
        cyc(0, 0, 0, 0, 0, 0);
        n_chk++; if (o0 !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", o0); end
        cyc(0, 0, 0, 0, 1, 0);
        n_chk++; if (o0 !== 1'b0 || v0 !== 1'b1) begin n_err++; $display("FAIL ovf_clear got %b/%b exp 0/1", o0, v0); end
        cyc(0, 0, 0, 0, 0, 1);
        n_chk++; if (v0 !== 1'b0) begin n_err++; $display("FAIL ovf_drain got %b exp 0", v0); end
    endtask

    task automatic test_back_to_back;
        cyc(1, 1, 'h31, 0, 0, 0);
        cyc(1, 2, 'h32, 0, 0, 0);
        cyc(1, 3, 'h33, 0, 0, 0);
        n_chk++; if (v0 !== 1'b1 || r0 !== pack(1, 2, 3)) begin n_err++; $display("FAIL b2b_a got %b/%h exp 1/%h", v0, r0, pack(1, 2, 3)); end
        cyc(1, 4, 'h34, 0, 0, 0);
        cyc(1, 5, 'h35, 0, 0, 0);
        cyc(1, 6, 'h36, 0, 0, 1);
        n_chk++; if (v0 !== 1'b1 || o0 !== 1'b0) begin n_err++; $display("FAIL b2b_valid got %b/%b exp 1/0", v0, o0); end
        n_chk++; if (r0 !== pack(4, 5, 6) || i0 !== pack('h34, 'h35, 'h36)) begin n_err++; $display("FAIL b2b_data got %h/%h exp %h/%h", r0, i0, pack(4, 5, 6), pack('h34, 'h35, 'h36)); end
        n_chk++; if (r1 !== pack(6, 5, 4)) begin n_err++; $display("FAIL b2b_rev got %h exp %h", r1, pack(6, 5, 4)); end
        cyc(0, 0, 0, 0, 0, 1);
        n_chk++; if (v0 !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", v0); end
    endtask

    task automatic test_flush;
        cyc(1, 1, 'h41, 0, 0, 1);
        cyc(1, 2, 'h42, 0, 0, 1);
        n_chk++; if (f0 !== 2'd2) begin n_err++; $display("FAIL flush_pre got %0d exp 2", f0); end
        cyc(1, 9, 'h49, 1, 0, 1);
        n_chk++; if (f0 !== 2'd0 || v0 !== 1'b0) begin n_err++; $display("FAIL flush_fill got %0d/%b exp 0/0", f0, v0); end
        cyc(1, 4, 'h44, 0, 0, 1);
        n_chk++; if (f0 !== 2'd1) begin n_err++; $display("FAIL flush_next got %0d exp 1", f0); end
        cyc(1, 5, 'h45, 0, 0, 1);
        cyc(1, 6, 'h46, 0, 0, 1);
        n_chk++; if (v0 !== 1'b1 || r0 !== pack(4, 5, 6) || i0 !== pack('h44, 'h45, 'h46))
            begin n_err++; $display("FAIL flush_frame got %b/%h/%h exp 1/%h/%h", v0, r0, i0, pack(4, 5, 6), pack('h44, 'h45, 'h46)); end
        n_chk++; if (r1 !== pack(6, 5, 4)) begin n_err++; $display("FAIL flush_rev got %h exp %h", r1, pack(6, 5, 4)); end
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_async_reset;
        for (int k = 1; k <= 5; k++) cyc(1, k, 'h50 + k, 0, 0, 0);
        n_chk++; if (f0 !== 2'd2 || v0 !== 1'b1) begin n_err++; $display("FAIL arst_pre got %0d/%b exp 2/1", f0, v0); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if (v0 !== 1'b0 || f0 !== 2'd0 || o0 !== 1'b0) begin n_err++; $display("FAIL arst_ctl got %b/%0d/%b exp 0/0/0", v0, f0, o0); end
        n_chk++; if (r0 !== 21'd0 || i0 !== 21'd0 || r1 !== 21'd0) begin n_err++; $display("FAIL arst_data got %h/%h/%h exp 0", r0, i0, r1); end
        @(negedge clock);
        reset = 1'b1;
        cyc(1, 7, 'h27, 0, 0, 1);
        n_chk++; if (f0 !== 2'd1 || v0 !== 1'b0) begin n_err++; $display("FAIL arst_first got %0d/%b exp 1/0", f0, v0); end
        cyc(1, 8, 'h28, 0, 0, 1);
        cyc(1, 9, 'h29, 0, 0, 1);
        n_chk++; if (v0 !== 1'b1 || r0 !== pack(7, 8, 9) || i0 !== pack('h27, 'h28, 'h29))
            begin n_err++; $display("FAIL arst_frame got %b/%h/%h exp 1/%h/%h", v0, r0, i0, pack(7, 8, 9), pack('h27, 'h28, 'h29)); end
        n_chk++; if (r1 !== pack(9, 8, 7)) begin n_err++; $display("FAIL arst_rev got %h exp %h", r1, pack(9, 8, 7)); end
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_clear_drop;
        for (int k = 1; k <= 5; k++) cyc(1, k, 'h60 + k, 0, 0, 0);
        cyc(1, 6, 'h66, 0, 1, 0);
        n_chk++; if (o0 !== 1'b1 || o1 !== 1'b1) begin n_err++; $display("FAIL clrdrop_set got %b/%b exp 1/1", o0, o1); end
        cyc(0, 0, 0, 0, 1, 0);
        n_chk++; if (o0 !== 1'b0) begin n_err++; $display("FAIL clrdrop_clear got %b exp 0", o0); end
        cyc(0, 0, 0, 0, 0, 1);
        n_chk++; if (v0 !== 1'b0 || r0 !== pack(1, 2, 3)) begin n_err++; $display("FAIL clrdrop_drain got %b/%h exp 0/%h", v0, r0, pack(1, 2, 3)); end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_inorder();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_clear_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
